// File: rtl/opacc_seq.sv
// Tile sequencer for the outer-product accumulator: takes one tile command and runs
// C preload, K outer-product beats and C drain, mapping valid/ready streams onto opacc strobes.
module opacc_seq #(
  parameter int vl   = 4,
  parameter int ml   = 4,
  parameter int XLEN = 64,
  parameter int KW   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [KW-1:0]        cmd_k,
  input  logic                 cmd_load_c,
  input  logic                 cin_valid,
  output logic                 cin_ready,
  input  logic [vl*XLEN-1:0]   cin_data,
  input  logic                 ab_in_valid,
  output logic                 ab_in_ready,
  input  logic [ml*XLEN-1:0]   a_data,
  input  logic [vl*XLEN-1:0]   b_data,
  output logic                 cout_valid,
  input  logic                 cout_ready,
  output logic [vl*XLEN-1:0]   cout_data,
  output logic                 cout_last,
  output logic                 busy,
  output logic                 ab_valid,
  output logic                 c_valid,
  output logic [ml*XLEN-1:0]   vi_a,
  output logic [vl*XLEN-1:0]   vi_b,
  output logic [vl*XLEN-1:0]   vi_c,
  input  logic [vl*XLEN-1:0]   vo_c
);

  localparam int RW = (ml > 1) ? $clog2(ml) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(ml - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   row_cnt, row_cnt_nxt;
  logic [KW-1:0]   k_cnt, k_cnt_nxt;
  logic            load_c_q, load_c_nxt;
  logic            row_last;
  logic            load_beat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      row_cnt  <= '0;
      k_cnt    <= '0;
      load_c_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      row_cnt  <= row_cnt_nxt;
      k_cnt    <= k_cnt_nxt;
      load_c_q <= load_c_nxt;
    end
  end

  assign row_last = (row_cnt == ROW_MAX);

  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    k_cnt_nxt   = k_cnt;
    load_c_nxt  = load_c_q;
    cmd_ready   = 1'b0;
    cin_ready   = 1'b0;
    ab_in_ready = 1'b0;
    cout_valid  = 1'b0;
    cout_last   = 1'b0;
    ab_valid    = 1'b0;
    c_valid     = 1'b0;
    vi_c        = '0;
    load_beat   = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          k_cnt_nxt   = cmd_k;
          load_c_nxt  = cmd_load_c;
          row_cnt_nxt = '0;
          state_nxt   = LOAD;
        end
      end

      LOAD: begin
        // Zero preload needs no upstream data, so it strobes every cycle.
        if (load_c_q) begin
          cin_ready = 1'b1;
          c_valid   = cin_valid;
          load_beat = cin_valid;
          if (cin_valid) vi_c = cin_data;
        end else begin
          c_valid   = 1'b1;
          load_beat = 1'b1;
        end
        if (load_beat) begin
          if (row_last) begin
            row_cnt_nxt = '0;
            state_nxt   = (k_cnt != '0) ? COMPUTE : DRAIN;
          end else begin
            row_cnt_nxt = row_cnt + RW'(1);
          end
        end
      end

      COMPUTE: begin
        ab_in_ready = 1'b1;
        ab_valid    = ab_in_valid;
        if (ab_in_valid) begin
          k_cnt_nxt = k_cnt - KW'(1);
          if (k_cnt == KW'(1)) state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        // Each consumed row shifts a zero row into opacc, exposing the next one on vo_c.
        cout_valid = 1'b1;
        cout_last  = row_last;
        c_valid    = cout_ready;
        if (cout_ready) begin
          if (row_last) begin
            row_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            row_cnt_nxt = row_cnt + RW'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign vi_a      = a_data;
  assign vi_b      = b_data;
  assign cout_data = vo_c;

endmodule

// File: tb/tb_opacc_seq.sv
// Bench for opacc_seq: a behavioural opacc model closes the loop, and a scoreboard
// compares drained rows against tile results computed directly from the stimulus.
module tb_opacc_seq;

  localparam int VL   = 4;
  localparam int ML   = 4;
  localparam int XLEN = 64;
  localparam int KW   = 16;

  typedef logic [XLEN-1:0]    elem_t;
  typedef logic [VL*XLEN-1:0] row_t;
  typedef logic [ML*XLEN-1:0] avec_t;
  typedef struct { logic [KW-1:0] k; logic load_c; } cmd_t;
  typedef struct { avec_t a; row_t b; } ab_t;
  typedef struct { row_t data; logic last; } exp_t;

  logic          clk, reset_n;
  logic          cmd_valid, cmd_ready, cmd_load_c;
  logic [KW-1:0] cmd_k;
  logic          cin_valid, cin_ready;
  row_t          cin_data;
  logic          ab_in_valid, ab_in_ready;
  avec_t         a_data;
  row_t          b_data;
  logic          cout_valid, cout_ready, cout_last, busy, ab_valid, c_valid;
  row_t          cout_data, vi_b, vi_c, vo_c;
  avec_t         vi_a;

  opacc_seq #(.vl(VL), .ml(ML), .XLEN(XLEN), .KW(KW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k), .cmd_load_c(cmd_load_c),
    .cin_valid(cin_valid), .cin_ready(cin_ready), .cin_data(cin_data),
    .ab_in_valid(ab_in_valid), .ab_in_ready(ab_in_ready), .a_data(a_data), .b_data(b_data),
    .cout_valid(cout_valid), .cout_ready(cout_ready), .cout_data(cout_data), .cout_last(cout_last),
    .busy(busy), .ab_valid(ab_valid), .c_valid(c_valid),
    .vi_a(vi_a), .vi_b(vi_b), .vi_c(vi_c), .vo_c(vo_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream opacc: accumulate outer products, or shift rows in at row 0; vo_c is row ML-1.
  elem_t creg [ML][VL];
  always @(posedge clk) begin
    if (ab_valid) begin
      for (int r = 0; r < ML; r++)
        for (int c = 0; c < VL; c++)
          creg[r][c] <= creg[r][c] + vi_a[r*XLEN +: XLEN] * vi_b[c*XLEN +: XLEN];
    end else if (c_valid) begin
      for (int c = 0; c < VL; c++) begin
        creg[0][c] <= vi_c[c*XLEN +: XLEN];
        for (int r = 1; r < ML; r++) creg[r][c] <= creg[r-1][c];
      end
    end
  end
  always_comb begin
    vo_c = '0;
    for (int c = 0; c < VL; c++) vo_c[c*XLEN +: XLEN] = creg[ML-1][c];
  end

  cmd_t cmd_q[$];
  row_t cin_q[$];
  ab_t  ab_q[$];
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0;
  int n_ab = 0, n_c = 0, n_drain = 0, n_tiles = 0, total_k = 0;
  int stall_pct = 0;
  bit b2b_pend = 0;

  row_t  t_rows [ML];
  avec_t t_a[$];
  row_t  t_b[$];

  task automatic chk(input string name, input row_t got, input row_t req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Expected tile: drained row n = n-th loaded row + sum_k a_k[ML-1-n] * b_k.
  task automatic push_tile(input int k, input logic load_c);
    elem_t acc [ML][VL];
    exp_t e;
    for (int n = 0; n < ML; n++)
      for (int c = 0; c < VL; c++)
        acc[n][c] = load_c ? t_rows[n][c*XLEN +: XLEN] : '0;
    for (int kk = 0; kk < k; kk++)
      for (int n = 0; n < ML; n++)
        for (int c = 0; c < VL; c++)
          acc[n][c] += t_a[kk][(ML-1-n)*XLEN +: XLEN] * t_b[kk][c*XLEN +: XLEN];
    for (int n = 0; n < ML; n++) begin
      for (int c = 0; c < VL; c++) e.data[c*XLEN +: XLEN] = acc[n][c];
      e.last = (n == ML-1);
      exp_q.push_back(e);
    end
    if (load_c) for (int n = 0; n < ML; n++) cin_q.push_back(t_rows[n]);
    for (int kk = 0; kk < k; kk++) ab_q.push_back('{a: t_a[kk], b: t_b[kk]});
    cmd_q.push_back('{k: KW'(k), load_c: load_c});
    n_tiles++;
    total_k += k;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && cmd_q.size() == 0 && !busy) break;
    end
    if (i == budget) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: %0d rows still expected after %0d cycles", exp_q.size(), budget);
    end
  endtask

  // Command driver: cmd_valid held high while commands are pending.
  initial begin : drv_cmd
    bit fire;
    cmd_valid = 0; cmd_k = '0; cmd_load_c = 0;
    forever begin
      @(negedge clk);
      fire = cmd_valid && cmd_ready && reset_n;
      @(posedge clk); #1;
      if (fire && cmd_q.size() > 0) cmd_q.delete(0);
      if (cmd_q.size() > 0) begin
        cmd_valid = 1; cmd_k = cmd_q[0].k; cmd_load_c = cmd_q[0].load_c;
      end else cmd_valid = 0;
    end
  end

  initial begin : drv_cin
    bit fire;
    cin_valid = 0; cin_data = '0;
    forever begin
      @(negedge clk);
      fire = cin_valid && cin_ready && reset_n;
      @(posedge clk); #1;
      if (fire && cin_q.size() > 0) cin_q.delete(0);
      if (cin_q.size() == 0) cin_valid = 0;
      else begin
        if (!(cin_valid && !fire)) cin_valid = ($urandom_range(0, 99) >= stall_pct);
        cin_data = cin_q[0];
      end
    end
  end

  initial begin : drv_ab
    bit fire;
    ab_in_valid = 0; a_data = '0; b_data = '0;
    forever begin
      @(negedge clk);
      fire = ab_in_valid && ab_in_ready && reset_n;
      @(posedge clk); #1;
      if (fire && ab_q.size() > 0) ab_q.delete(0);
      if (ab_q.size() == 0) ab_in_valid = 0;
      else begin
        if (!(ab_in_valid && !fire)) ab_in_valid = ($urandom_range(0, 99) >= stall_pct);
        a_data = ab_q[0].a; b_data = ab_q[0].b;
      end
    end
  end

  initial begin : drv_cout
    cout_ready = 0;
    forever begin
      @(posedge clk); #1;
      cout_ready = ($urandom_range(0, 99) >= stall_pct);
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on each drain handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      chk("strobe_excl", row_t'(ab_valid && c_valid), '0);
      if (busy && !c_valid) chk("vi_c_zero", vi_c, '0);
      if (ab_valid) n_ab++;
      if (c_valid) n_c++;
      if (b2b_pend) begin
        chk("b2b_cmd_ready", row_t'(cmd_ready), row_t'(1));
        b2b_pend = 0;
      end
      if (cout_valid && cout_ready && reset_n) begin
        n_drain++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_row: got %0h required no row", cout_data);
        end else begin
          e = exp_q.pop_front();
          chk("cout_data", cout_data, e.data);
          chk("cout_last", row_t'(cout_last), row_t'(e.last));
        end
        if (cout_last && cmd_valid) b2b_pend = 1;
      end
    end
  end

  initial begin : main
    int i;
    reset_n = 0;
    #1;
    chk("rst_cmd_ready", row_t'(cmd_ready), row_t'(1));
    chk("rst_busy", row_t'(busy), '0);
    chk("rst_cout_valid", row_t'(cout_valid), '0);
    chk("rst_cout_last", row_t'(cout_last), '0);
    chk("rst_strobes", row_t'({ab_valid, c_valid, cin_ready, ab_in_ready}), '0);
    repeat (2) @(negedge clk);
    reset_n = 1;

    // Abort a tile mid-COMPUTE with an asynchronous reset.
    cmd_q.push_back('{k: KW'(5), load_c: 1'b0});
    for (int kk = 0; kk < 2; kk++) ab_q.push_back('{a: avec_t'(kk + 1), b: row_t'(kk + 1)});
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ab_in_ready) break;
    end
    if (i == 50) begin
      n_cmp++; n_bad++;
      $display("FAIL reach_compute: got ab_in_ready 0 required 1 within 50 cycles");
    end
    #2 reset_n = 0;
    #1;
    chk("mid_rst_cmd_ready", row_t'(cmd_ready), row_t'(1));
    chk("mid_rst_busy", row_t'(busy), '0);
    chk("mid_rst_strobes", row_t'({ab_valid, c_valid, cout_valid, ab_in_ready}), '0);
    cmd_q.delete(); ab_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
    n_ab = 0; n_c = 0; n_drain = 0;

    // Directed tiles, queued together so they run back to back.
    t_a.delete(); t_b.delete();
    t_a.push_back({64'd1, 64'd2, 64'd3, 64'd4});
    t_b.push_back({VL{64'd1}});
    push_tile(1, 1'b0);

    t_a.delete(); t_b.delete();
    for (int n = 0; n < ML; n++) t_rows[n] = {VL{64'd10}};
    for (int kk = 0; kk < 2; kk++) begin
      t_a.push_back({ML{64'd1}});
      t_b.push_back({VL{64'd1}});
    end
    push_tile(2, 1'b1);

    for (int n = 0; n < ML; n++) t_rows[n] = {VL{64'(5 + n)}};
    push_tile(0, 1'b1);
    wait_done(2000);

    // Randomized tiles with backpressure on every stream.
    stall_pct = 40;
    for (int t = 0; t < 20; t++) begin
      int k;
      k = $urandom_range(0, 6);
      t_a.delete(); t_b.delete();
      for (int n = 0; n < ML; n++)
        for (int c = 0; c < VL; c++) t_rows[n][c*XLEN +: XLEN] = {$urandom, $urandom};
      for (int kk = 0; kk < k; kk++) begin
        avec_t av;
        row_t  bv;
        for (int r = 0; r < ML; r++) av[r*XLEN +: XLEN] = {$urandom, $urandom};
        for (int c = 0; c < VL; c++) bv[c*XLEN +: XLEN] = {$urandom, $urandom};
        t_a.push_back(av);
        t_b.push_back(bv);
      end
      push_tile(k, 1'($urandom_range(0, 1)));
    end
    wait_done(8000);
    stall_pct = 0;
    repeat (3) @(negedge clk);

    chk("ab_strobe_count", row_t'(n_ab), row_t'(total_k));
    chk("c_strobe_count", row_t'(n_c), row_t'(2 * ML * n_tiles));
    chk("drain_count", row_t'(n_drain), row_t'(ML * n_tiles));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/opacc_seq.md
Name: opacc_seq

Overview:
- Sequencer directly upstream of the outer-product accumulator (opacc) in the MPU datapath.
- Accepts a tile command, then drives opacc through three phases: C-tile preload, K outer-product beats, and C-tile drain.
- Converts valid/ready operand and result streams into opacc's ab_valid/c_valid strobes, applying backpressure on every stream.

Parameters:
- vl, 4, columns per C row / elements in B vector; must equal ml
- ml, 4, rows of the C tile / elements in A vector
- XLEN, 64, element width in bits
- KW, 16, width of the K-count field

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  tile command valid
- cmd_ready  out  1  sequencer idle, command accepted when both high
- cmd_k  in  KW  number of A/B outer-product beats (0 allowed)
- cmd_load_c  in  1  1: preload C from cin stream; 0: preload zeros
- cin_valid  in  1  C row input valid
- cin_ready  out  1  C row accepted
- cin_data  in  vl*XLEN  C row
- ab_in_valid  in  1  A/B pair valid
- ab_in_ready  out  1  A/B pair accepted
- a_data  in  ml*XLEN  A column vector
- b_data  in  vl*XLEN  B row vector
- cout_valid  out  1  result row valid
- cout_ready  in  1  result row consumed
- cout_data  out  vl*XLEN  result row (= vo_c)
- cout_last  out  1  final row of tile
- busy  out  1  state != IDLE
- ab_valid  out  1  to opacc
- c_valid  out  1  to opacc
- vi_a  out  ml*XLEN  to opacc, = a_data
- vi_b  out  vl*XLEN  to opacc, = b_data
- vi_c  out  vl*XLEN  to opacc
- vo_c  in  vl*XLEN  from opacc, last row of its C register

Behaviour:
- States: IDLE, LOAD, COMPUTE, DRAIN. Registers: state, row_cnt (0..ml-1), k_cnt (KW bits), load_c_q.
- Reset (reset_n low, async): state=IDLE, counters=0, load_c_q=0. Outputs then: cmd_ready=1, all other valids/readies/strobes=0, busy=0, cout_last=0.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_k and cmd_load_c, row_cnt=0, go to LOAD.
- LOAD, load_c_q=1:
  - cin_ready=1, c_valid=cin_valid, vi_c=cin_data.
  - Each accepted beat increments row_cnt.
  - The first accepted row ends in opacc row ml-1 (first drained).
- LOAD, load_c_q=0:
  - cin_ready=0, c_valid=1 every cycle, vi_c=0.
  - Exactly ml cycles.
- LOAD exit: after beat ml-1, go to COMPUTE if k_cnt!=0, else DRAIN; row_cnt=0.
- COMPUTE:
  - ab_in_ready=1, ab_valid=ab_in_valid.
  - Each accepted beat decrements k_cnt. The beat that takes k_cnt to 0 moves to DRAIN.
  - ab_in_valid low stalls; no strobe is issued.
- DRAIN:
  - cout_valid=1, cout_data=vo_c, c_valid=cout_ready, vi_c=0 (shifts zeros in).
  - cout_last=1 when row_cnt==ml-1.
  - Each accepted row increments row_cnt. After row ml-1, go to IDLE.
- Strobe exclusivity: ab_valid and c_valid are never both 1. ab_valid is 0 outside COMPUTE. c_valid is 0 outside LOAD/DRAIN.
- No operand arithmetic here. vi_a/vi_b are wired straight through and are don't-care when ab_valid=0. vi_c=0 whenever c_valid=0.
- Back-to-back: a new command is accepted only in IDLE, so there is one bubble cycle between the last drain beat and the next LOAD.
- Reset mid-operation returns to IDLE immediately. opacc contents are not cleared by this block.
- cmd_k max 2^KW-1. Count uses a full KW-bit down-counter with no wrap.

Test Plan:
- Reset check: hold reset_n low mid-COMPUTE -> state IDLE, cmd_ready=1, ab_valid=c_valid=cout_valid=0 without waiting for a clk edge.
- Zero-load, identity-ish: cmd_k=1, load_c=0, a={1,2,3,4}, b={1,1,1,1} -> 4 drain rows {1,1,1,1},{2,2,2,2},{3,3,3,3},{4,4,4,4} (row ml-1 first). cout_last is set on the 4th row.
- Preload plus accumulate: load_c=1, C rows all 10, cmd_k=2, a=b=all 1 twice -> every drained element = 12; the first-loaded C row drains first.
- K=0: load_c=1 rows 5,6,7,8 -> LOAD goes straight to DRAIN, and the rows come back in load order with no ab_valid pulse.
- Backpressure: toggle cin_valid, ab_in_valid and cout_ready randomly -> c_valid/ab_valid only pulse on handshakes; exactly ml loads, K ab beats and ml drains occur; ab_valid and c_valid are never high together.
- Back-to-back commands: cmd_valid held high -> second command accepted one cycle after the first cout_last handshake; results are independent (second tile load_c=0, no residue).
